// File: rtl/sa_host_pkg.sv
// ============================================================================
// Module : sa_host_pkg
// Shared constants and state encodings for the systolic-array host controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sa_host_pkg;

    localparam int A_DEPTH = 64;
    localparam int B_DEPTH = 64;
    localparam int I_DEPTH = 4;
    localparam int O_DEPTH = 256;
    localparam int DW      = 16;
    localparam int IW      = 5;
    localparam int RD_LAT  = 2;

    localparam int AW_A  = $clog2(A_DEPTH);
    localparam int AW_B  = $clog2(B_DEPTH);
    localparam int AW_I  = $clog2(I_DEPTH);
    localparam int AW_O  = $clog2(O_DEPTH);
    localparam int CNT_W = AW_A;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_A    = 3'd1,
        S_LOAD_B    = 3'd2,
        S_LOAD_I    = 3'd3,
        S_START     = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_READ      = 3'd6
    } host_state_e;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_RD_ADDR = 2'd1,
        FS_RD_WAIT = 2'd2,
        FS_RD_OUT  = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/sa_host_ctrl_if.sv
// ============================================================================
// Module : sa_host_ctrl_if
// Stream, memory-port and run-control bundle between host controller and system.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sa_host_ctrl_if;
    import sa_host_pkg::*;

    logic            go;
    logic            busy;
    logic            seq_done;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic [AW_A-1:0] addrA;
    logic            enA;
    logic [DW-1:0]   dataA;
    logic [AW_B-1:0] addrB;
    logic            enB;
    logic [DW-1:0]   dataB;
    logic [AW_I-1:0] addrI;
    logic            enI;
    logic [IW-1:0]   dataI;
    logic [AW_O-1:0] addrO;
    logic [DW-1:0]   dataO;
    logic            ap_start;
    logic            ap_done;

    modport master (
        input  go, s_valid, s_data, m_ready, dataO, ap_done,
        output busy, seq_done, s_ready, m_valid, m_data, m_last,
               addrA, enA, dataA, addrB, enB, dataB, addrI, enI, dataI,
               addrO, ap_start
    );

    modport slave (
        output go, s_valid, s_data, m_ready, dataO, ap_done,
        input  busy, seq_done, s_ready, m_valid, m_data, m_last,
               addrA, enA, dataA, addrB, enB, dataB, addrI, enI, dataI,
               addrO, ap_start
    );

endinterface

`default_nettype wire

// File: rtl/sa_out_fetch.sv
// ============================================================================
// Module : sa_out_fetch
// Walks the output memory through its fixed-latency read port into a result stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sa_out_fetch
    import sa_host_pkg::*;
#(
    parameter int LATENCY = RD_LAT
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            fetch_start_i,
    output logic                 fetch_done_o,
    output logic [AW_O-1:0]      addrO_o,
    input  wire logic [DW-1:0]   dataO_i,
    output logic                 m_valid_o,
    input  wire logic            m_ready_i,
    output logic [DW-1:0]        m_data_o,
    output logic                 m_last_o
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [AW_O-1:0] LAST_IDX = AW_O'(O_DEPTH - 1);

    fetch_state_e    fstate_q, fstate_d;
    logic [AW_O-1:0] idx_q, idx_d;
    logic [AW_O-1:0] addr_q, addr_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [DW-1:0]   mdata_q, mdata_d;
    logic            mvalid_q, mvalid_d;
    logic            mlast_q, mlast_d;
    logic            done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fstate_q <= FS_IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            lat_q    <= '0;
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fstate_q <= fstate_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            lat_q    <= lat_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            mlast_q  <= mlast_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        fstate_d = fstate_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        lat_d    = lat_q;
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q;
        mlast_d  = mlast_q;
        done_d   = 1'b0;
        case (fstate_q)
            FS_IDLE: begin
                if (fetch_start_i) begin
                    idx_d    = '0;
                    fstate_d = FS_RD_ADDR;
                end
            end
            FS_RD_ADDR: begin
                addr_d   = idx_q;
                lat_d    = LAT_W'(LATENCY - 1);
                fstate_d = FS_RD_WAIT;
            end
            FS_RD_WAIT: begin
                // Capture lands LATENCY edges after the address register updated.
                if (lat_q == '0) begin
                    mdata_d  = dataO_i;
                    mvalid_d = 1'b1;
                    mlast_d  = (idx_q == LAST_IDX);
                    fstate_d = FS_RD_OUT;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            FS_RD_OUT: begin
                if (m_ready_i) begin
                    mvalid_d = 1'b0;
                    mlast_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        done_d   = 1'b1;
                        fstate_d = FS_IDLE;
                    end else begin
                        idx_d    = idx_q + AW_O'(1);
                        fstate_d = FS_RD_ADDR;
                    end
                end
            end
            default: fstate_d = FS_IDLE;
        endcase
    end

    assign fetch_done_o = done_q;
    assign addrO_o      = addr_q;
    assign m_valid_o    = mvalid_q;
    assign m_data_o     = mdata_q;
    assign m_last_o     = mlast_q;

endmodule

`default_nettype wire

// File: rtl/sa_host_ctrl.sv
// ============================================================================
// Module : sa_host_ctrl
// Loads A/B/instruction memories from a word stream, runs the array, streams results.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sa_host_ctrl
    import sa_host_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    sa_host_ctrl_if.master bus
);

    host_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            s_ready_q, s_ready_d;
    logic            busy_q, busy_d;
    logic [AW_A-1:0] addrA_q, addrA_d;
    logic [DW-1:0]   dataA_q, dataA_d;
    logic            enA_q, enA_d;
    logic [AW_B-1:0] addrB_q, addrB_d;
    logic [DW-1:0]   dataB_q, dataB_d;
    logic            enB_q, enB_d;
    logic [AW_I-1:0] addrI_q, addrI_d;
    logic [IW-1:0]   dataI_q, dataI_d;
    logic            enI_q, enI_d;
    logic            ap_start_q, ap_start_d;

    logic            w_hs;
    logic            w_fetch_start;
    logic            w_fetch_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            addrA_q    <= '0;
            dataA_q    <= '0;
            enA_q      <= 1'b0;
            addrB_q    <= '0;
            dataB_q    <= '0;
            enB_q      <= 1'b0;
            addrI_q    <= '0;
            dataI_q    <= '0;
            enI_q      <= 1'b0;
            ap_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            addrA_q    <= addrA_d;
            dataA_q    <= dataA_d;
            enA_q      <= enA_d;
            addrB_q    <= addrB_d;
            dataB_q    <= dataB_d;
            enB_q      <= enB_d;
            addrI_q    <= addrI_d;
            dataI_q    <= dataI_d;
            enI_q      <= enI_d;
            ap_start_q <= ap_start_d;
        end
    end

    assign w_hs = s_ready_q & bus.s_valid;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addrA_d       = addrA_q;
        dataA_d       = dataA_q;
        enA_d         = 1'b0;
        addrB_d       = addrB_q;
        dataB_d       = dataB_q;
        enB_d         = 1'b0;
        addrI_d       = addrI_q;
        dataI_d       = dataI_q;
        enI_d         = 1'b0;
        ap_start_d    = 1'b0;
        w_fetch_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (w_hs) begin
                    addrA_d = cnt_q[AW_A-1:0];
                    dataA_d = bus.s_data;
                    enA_d   = 1'b1;
                    if (cnt_q == CNT_W'(A_DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_B: begin
                if (w_hs) begin
                    addrB_d = cnt_q[AW_B-1:0];
                    dataB_d = bus.s_data;
                    enB_d   = 1'b1;
                    if (cnt_q == CNT_W'(B_DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_I;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_I: begin
                if (w_hs) begin
                    addrI_d = cnt_q[AW_I-1:0];
                    dataI_d = bus.s_data[IW-1:0];
                    enI_d   = 1'b1;
                    if (cnt_q == CNT_W'(I_DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_START: begin
                ap_start_d = 1'b1;
                state_d    = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // ap_done is only trusted once the start pulse has dropped.
                if (!ap_start_q && bus.ap_done) begin
                    w_fetch_start = 1'b1;
                    state_d       = S_READ;
                end
            end
            S_READ: begin
                if (w_fetch_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        s_ready_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_B) || (state_d == S_LOAD_I);
        busy_d    = (state_d != S_IDLE);
    end

    sa_out_fetch #(
        .LATENCY (RD_LAT)
    ) u_fetch (
        .clk           (clk),
        .rst           (rst),
        .fetch_start_i (w_fetch_start),
        .fetch_done_o  (w_fetch_done),
        .addrO_o       (bus.addrO),
        .dataO_i       (bus.dataO),
        .m_valid_o     (bus.m_valid),
        .m_ready_i     (bus.m_ready),
        .m_data_o      (bus.m_data),
        .m_last_o      (bus.m_last)
    );

    assign bus.busy     = busy_q;
    assign bus.seq_done = w_fetch_done;
    assign bus.s_ready  = s_ready_q;
    assign bus.addrA    = addrA_q;
    assign bus.dataA    = dataA_q;
    assign bus.enA      = enA_q;
    assign bus.addrB    = addrB_q;
    assign bus.dataB    = dataB_q;
    assign bus.enB      = enB_q;
    assign bus.addrI    = addrI_q;
    assign bus.dataI    = dataI_q;
    assign bus.enI      = enI_q;
    assign bus.ap_start = ap_start_q;

endmodule

`default_nettype wire

// File: tb/tb_sa_host_ctrl.sv
// ============================================================================
// Module : tb_sa_host_ctrl
// Scoreboard bench for sa_host_ctrl with a mock array top (fixed-latency output memory).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sa_host_ctrl;
    import sa_host_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sa_host_ctrl_if bus();

    sa_host_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int ap_start_cnt = 0;
    int seq_done_cnt = 0;

    logic [21:0] expA_q[$];
    logic [21:0] expB_q[$];
    logic [6:0]  expI_q[$];
    logic [16:0] expR_q[$];
    logic [15:0] instr_w[4];

    // Mock array top: ap_done 50 cycles after ap_start, read data = addr*3-7 after RD_LAT edges.
    int         done_cnt;
    logic [7:0] pipe_addr;
    always @(posedge clk) begin
        pipe_addr <= bus.addrO;
        if (rst) begin
            done_cnt    <= 0;
            bus.ap_done <= 1'b0;
        end else if (bus.ap_start) begin
            done_cnt    <= 50;
            bus.ap_done <= 1'b0;
        end else if (done_cnt > 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) bus.ap_done <= 1'b1;
        end
    end
    assign bus.dataO = 16'(int'(pipe_addr) * 3 - 7);

    logic [21:0] monA_e, monB_e;
    logic [6:0]  monI_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ap_start) ap_start_cnt++;
            if (bus.seq_done) seq_done_cnt++;
            if (bus.enA || bus.enB || bus.enI || bus.ap_start) begin
                tests_run++;
                if ((int'(bus.enA) + int'(bus.enB) + int'(bus.enI) + int'(bus.ap_start)) != 1) begin
                    tests_failed++;
                    $display("FAIL strobe_onehot got enA=%b enB=%b enI=%b ap_start=%b expected exactly one",
                             bus.enA, bus.enB, bus.enI, bus.ap_start);
                end
            end
            if (bus.enA) begin
                tests_run++;
                if (expA_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wrA_unexpected got addr=%0d data=%h expected no write", bus.addrA, bus.dataA);
                end else begin
                    monA_e = expA_q.pop_front();
                    if ({bus.addrA, bus.dataA} !== monA_e) begin
                        tests_failed++;
                        $display("FAIL wrA got addr=%0d data=%h expected addr=%0d data=%h",
                                 bus.addrA, bus.dataA, monA_e[21:16], monA_e[15:0]);
                    end
                end
            end
            if (bus.enB) begin
                tests_run++;
                if (expB_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wrB_unexpected got addr=%0d data=%h expected no write", bus.addrB, bus.dataB);
                end else begin
                    monB_e = expB_q.pop_front();
                    if ({bus.addrB, bus.dataB} !== monB_e) begin
                        tests_failed++;
                        $display("FAIL wrB got addr=%0d data=%h expected addr=%0d data=%h",
                                 bus.addrB, bus.dataB, monB_e[21:16], monB_e[15:0]);
                    end
                end
            end
            if (bus.enI) begin
                tests_run++;
                if (expI_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL wrI_unexpected got addr=%0d data=%h expected no write", bus.addrI, bus.dataI);
                end else begin
                    monI_e = expI_q.pop_front();
                    if ({bus.addrI, bus.dataI} !== monI_e) begin
                        tests_failed++;
                        $display("FAIL wrI got addr=%0d data=%h expected addr=%0d data=%h",
                                 bus.addrI, bus.dataI, monI_e[6:5], monI_e[4:0]);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] get_word(input int pos);
        if (pos < 64)       return 16'(pos);
        else if (pos < 128) return 16'(-(pos - 64) - 1);
        else                return instr_w[pos - 128];
    endfunction

    task automatic pulse_go();
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic send_stream(input int n, input bit gaps);
        int pos = 0;
        int pushed = 0;
        int guard = 0;
        bit v = 1'b0;
        bit r = 1'b0;
        logic [15:0] w;
        while (pos < n && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (v && r) pos++;
            if (pos >= n) break;
            w = get_word(pos);
            if (pushed == pos) begin
                if (pos < 64)       expA_q.push_back({6'(pos), w});
                else if (pos < 128) expB_q.push_back({6'(pos - 64), w});
                else                expI_q.push_back({2'(pos - 128), w[4:0]});
                pushed++;
            end
            v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.s_valid = v;
            bus.s_data  = w;
            r = bus.s_ready;
        end
        bus.s_valid = 1'b0;
        tests_run++;
        if (pos != n) begin
            tests_failed++;
            $display("FAIL stream_timeout got %0d words accepted expected %0d", pos, n);
        end
    endtask

    task automatic run_full(input bit gaps, input bit bp, input bit glitch);
        int got = 0;
        int stall = 0;
        int guard = 0;
        logic [16:0] e;
        ap_start_cnt = 0;
        seq_done_cnt = 0;
        expR_q.delete();
        for (int i = 0; i < O_DEPTH; i++) expR_q.push_back({(i == O_DEPTH - 1), 16'(i * 3 - 7)});
        pulse_go();
        tests_run++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL go_accept got s_ready=%b busy=%b expected 1 1", bus.s_ready, bus.busy);
        end
        send_stream(A_DEPTH + B_DEPTH + I_DEPTH, gaps);
        tests_run++;
        if (bus.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL s_ready_drop got %b expected 0", bus.s_ready);
        end
        if (glitch) begin
            repeat (10) @(negedge clk);
            bus.go = 1'b1;
            @(negedge clk);
            bus.go = 1'b0;
        end
        bus.m_ready = 1'b0;
        while (got < O_DEPTH && guard < 40000) begin
            @(negedge clk);
            guard++;
            bus.go = (glitch && got == 100 && bus.m_valid);
            if (bus.m_valid) begin
                e = expR_q[0];
                if (bp && (got % 3 == 2) && stall < 5) begin
                    bus.m_ready = 1'b0;
                    tests_run++;
                    if (bus.m_data !== e[15:0] || bus.addrO !== 8'(got)) begin
                        tests_failed++;
                        $display("FAIL stall_hold got data=%h addrO=%0d expected data=%h addrO=%0d",
                                 bus.m_data, bus.addrO, e[15:0], got);
                    end
                    stall++;
                end else begin
                    e = expR_q.pop_front();
                    tests_run++;
                    if (bus.m_data !== e[15:0] || bus.m_last !== e[16]) begin
                        tests_failed++;
                        $display("FAIL result[%0d] got data=%h last=%b expected data=%h last=%b",
                                 got, bus.m_data, bus.m_last, e[15:0], e[16]);
                    end
                    bus.m_ready = 1'b1;
                    got++;
                    stall = 0;
                end
            end else begin
                bus.m_ready = 1'b0;
            end
        end
        bus.go = 1'b0;
        tests_run++;
        if (got != O_DEPTH) begin
            tests_failed++;
            $display("FAIL result_timeout got %0d results expected %0d", got, O_DEPTH);
        end
        guard = 0;
        do begin
            @(negedge clk);
            bus.m_ready = 1'b0;
            guard++;
        end while (bus.busy && guard < 20);
        repeat (3) @(negedge clk);
        tests_run++;
        if (seq_done_cnt != 1 || ap_start_cnt != 1) begin
            tests_failed++;
            $display("FAIL pulse_counts got seq_done=%0d ap_start=%0d expected 1 1", seq_done_cnt, ap_start_cnt);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL end_idle got busy=%b m_valid=%b expected 0 0", bus.busy, bus.m_valid);
        end
        tests_run++;
        if (expA_q.size() + expB_q.size() + expI_q.size() + expR_q.size() != 0) begin
            tests_failed++;
            $display("FAIL missing_items got A=%0d B=%0d I=%0d R=%0d left expected 0",
                     expA_q.size(), expB_q.size(), expI_q.size(), expR_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.seq_done, bus.s_ready, bus.m_valid, bus.m_last, bus.enA, bus.enB, bus.enI, bus.ap_start} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_flags got busy=%b seq_done=%b s_ready=%b m_valid=%b m_last=%b en=%b%b%b ap_start=%b expected all 0",
                     bus.busy, bus.seq_done, bus.s_ready, bus.m_valid, bus.m_last, bus.enA, bus.enB, bus.enI, bus.ap_start);
        end
        tests_run++;
        if ({bus.addrA, bus.dataA, bus.addrB, bus.dataB, bus.addrI, bus.dataI} !== '0) begin
            tests_failed++;
            $display("FAIL reset_wrports got addrA=%0d dataA=%h addrB=%0d dataB=%h addrI=%0d dataI=%h expected 0",
                     bus.addrA, bus.dataA, bus.addrB, bus.dataB, bus.addrI, bus.dataI);
        end
        tests_run++;
        if (bus.addrO !== 8'd0 || bus.m_data !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_rdport got addrO=%0d m_data=%h expected 0 0", bus.addrO, bus.m_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        instr_w[0] = 16'd4; instr_w[1] = 16'd8; instr_w[2] = 16'd16; instr_w[3] = 16'd0;
        run_full(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_input_gaps();
        // s_valid while idle must be ignored
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hABCD;
        repeat (4) @(negedge clk);
        tests_run++;
        if (bus.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_s_ready got %b expected 0", bus.s_ready);
        end
        bus.s_valid = 1'b0;
        run_full(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_full(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_instr_trunc();
        instr_w[0] = 16'hFFE3; instr_w[1] = 16'h0021; instr_w[2] = 16'h8007; instr_w[3] = 16'hFFFF;
        run_full(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        instr_w[0] = 16'd4; instr_w[1] = 16'd8; instr_w[2] = 16'd16; instr_w[3] = 16'd0;
        pulse_go();
        send_stream(20, 1'b0);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h5555;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({bus.enA, bus.enB, bus.enI, bus.ap_start, bus.m_valid, bus.s_ready, bus.busy} !== 7'd0) begin
            tests_failed++;
            $display("FAIL mid_reset got en=%b%b%b ap_start=%b m_valid=%b s_ready=%b busy=%b expected all 0",
                     bus.enA, bus.enB, bus.enI, bus.ap_start, bus.m_valid, bus.s_ready, bus.busy);
        end
        repeat (4) @(negedge clk);
        bus.s_valid = 1'b0;
        tests_run++;
        if (expA_q.size() != 0) begin
            tests_failed++;
            $display("FAIL mid_load_writes got %0d pending expected 0", expA_q.size());
        end
        expA_q.delete();
        run_full(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_go_ignored();
        run_full(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.go      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'd0;
        bus.m_ready = 1'b0;
        test_reset();
        test_full_run();
        test_input_gaps();
        test_backpressure();
        test_instr_trunc();
        test_reset_mid_load();
        test_go_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
